// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the 9-bit ALU and its multi-cycle sequencer.
//   DATA_W      : datapath width of the ALU (fixed at 9)
//   alu_cmd_e   : ALU command encodings
//   seq_op_e    : sequencer operations (SHL, MUL, two reserved codes)
//   seq_state_e : sequencer FSM states
// ---------------------------------------------------------------------------
package alu_pkg;

   localparam int DATA_W = 9;

   typedef enum logic [2:0] {
      ADD = 3'b000,
      LSL = 3'b001,
      XOR = 3'b011,
      SUB = 3'b110,
      CMP = 3'b111
   } alu_cmd_e;

   typedef enum logic [1:0] {
      SHL   = 2'b00,
      MUL   = 2'b01,
      RSVD2 = 2'b10,
      RSVD3 = 2'b11
   } seq_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      EXEC = 2'b01,
      DONE = 2'b10
   } seq_state_e;

endpackage

// File: rtl/alu_seq_ctrl.sv
// ---------------------------------------------------------------------------
// alu_seq_ctrl
// Multi-cycle sequencer between the control FSM and the combinational 9-bit
// ALU. Runs variable shift-left (one ALU add per bit) and a 9x9 shift-add
// multiply (low 9 bits) by borrowing the ALU while busy.
//
// Ports:
//   clk, rst_n   : clock (rising edge), asynchronous active-low reset
//   start_i      : request, sampled only in IDLE
//   op_i         : 00=SHL, 01=MUL, 10/11 reserved (complete with result 0)
//   a_i, b_i     : operand A (shiftee/multiplicand), B (amount/multiplier)
//   busy_o       : high in EXEC and DONE
//   done_o       : one-cycle pulse, result valid
//   rslt_o       : result, held until the next accepted start completes
//   carry_o      : SHL last bit shifted out, MUL sticky overflow
//   alu_cmd_o    : ALU command (always ADD)
//   alu_a_o/b_o  : ALU operands, zero outside EXEC
//   alu_rslt_i   : ALU result, same cycle
//
// Build option:
//   MUL_EARLY_EXIT_EN : MUL leaves EXEC once no multiplier bits remain;
//                       results are unchanged, only latency shrinks.
// ---------------------------------------------------------------------------
module alu_seq_ctrl
   import alu_pkg::*;
#(
   parameter int W     = DATA_W,
   parameter int CNT_W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start_i,
   input  logic [1:0]   op_i,
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   output logic         busy_o,
   output logic         done_o,
   output logic [W-1:0] rslt_o,
   output logic         carry_o,
   output logic [2:0]   alu_cmd_o,
   output logic [W-1:0] alu_a_o,
   output logic [W-1:0] alu_b_o,
   input  logic [W-1:0] alu_rslt_i
);

   localparam logic [CNT_W-1:0] FULL_ITERS = CNT_W'(W);
   localparam logic [W-1:0]     MAX_SHIFT  = W'(W);

   seq_state_e       state;
   seq_op_e          op_q;
   logic [W-1:0]     acc;
   logic [W-1:0]     a_sh;
   logic [W-1:0]     mplr;
   logic [CNT_W-1:0] cnt;
   logic             ovf;

   logic             take_add;
   logic [W-1:0]     exec_acc;
   logic             exec_carry;
   logic             exec_last;

   // A MUL iteration only borrows the ALU when the current multiplier bit is set.
   assign take_add  = (op_q == MUL) && mplr[0];
   assign alu_cmd_o = ADD;

   // ALU operands are decoded from registered state only, so the ALU result
   // returns within the same cycle without a combinational loop through us.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path can
      // infer a latch.
      alu_a_o = '0;
      alu_b_o = '0;
      if (state == EXEC) begin
         if (op_q == SHL) begin
            alu_a_o = acc;
            alu_b_o = acc;
         end else if (take_add) begin
            alu_a_o = acc;
            alu_b_o = a_sh;
         end
      end
   end

   // Next accumulator / carry and termination for the current EXEC cycle.
   always_comb begin
      exec_acc   = acc;
      exec_carry = ovf;
      exec_last  = (cnt == CNT_W'(1));
      if (op_q == SHL) begin
         exec_acc   = alu_rslt_i;
         exec_carry = acc[W-1];           // bit lost by this doubling
      end else begin
         if (take_add) exec_acc = alu_rslt_i;
         // Overflow: the add wrapped, or a multiplicand bit falls off the top
         // while higher multiplier bits still need the shifted value.
         exec_carry = ovf
                    | (take_add && (alu_rslt_i < acc))
                    | (a_sh[W-1] && (mplr[W-1:1] != '0));
`ifdef MUL_EARLY_EXIT_EN
         exec_last  = (mplr[W-1:1] == '0);
`endif
      end
   end

   // NOTE: all state is reset asynchronously and updated with non-blocking
   // assignments only, so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         op_q    <= SHL;
         acc     <= '0;
         a_sh    <= '0;
         mplr    <= '0;
         cnt     <= '0;
         ovf     <= 1'b0;
         busy_o  <= 1'b0;
         done_o  <= 1'b0;
         rslt_o  <= '0;
         carry_o <= 1'b0;
      end else begin
         done_o <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start_i) begin
                  op_q   <= seq_op_e'(op_i);
                  acc    <= '0;
                  a_sh   <= a_i;
                  mplr   <= b_i;
                  ovf    <= 1'b0;
                  cnt    <= FULL_ITERS;
                  busy_o <= 1'b1;
                  unique case (seq_op_e'(op_i))
                     SHL: begin
                        if (b_i == '0) begin
                           state   <= DONE;
                           done_o  <= 1'b1;
                           rslt_o  <= a_i;
                           carry_o <= 1'b0;
                        end else begin
                           acc   <= a_i;
                           cnt   <= (b_i >= MAX_SHIFT) ? FULL_ITERS : b_i[CNT_W-1:0];
                           state <= EXEC;
                        end
                     end
                     MUL: begin
`ifdef MUL_EARLY_EXIT_EN
                        if (b_i == '0) begin
                           state   <= DONE;
                           done_o  <= 1'b1;
                           rslt_o  <= '0;
                           carry_o <= 1'b0;
                        end else begin
                           state <= EXEC;
                        end
`else
                        state <= EXEC;
`endif
                     end
                     default: begin
                        state   <= DONE;
                        done_o  <= 1'b1;
                        rslt_o  <= '0;
                        carry_o <= 1'b0;
                     end
                  endcase
               end
            end
            EXEC: begin
               acc  <= exec_acc;
               ovf  <= exec_carry;
               cnt  <= cnt - 1'b1;
               a_sh <= {a_sh[W-2:0], 1'b0};
               mplr <= mplr >> 1;
               if (exec_last) begin
                  state   <= DONE;
                  done_o  <= 1'b1;
                  rslt_o  <= exec_acc;
                  carry_o <= exec_carry;
               end
            end
            DONE: begin
               state  <= IDLE;
               busy_o <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_alu_seq_ctrl
// Directed bench for alu_seq_ctrl with a behavioural ADD-only ALU attached.
// A vector table covers SHL / MUL / reserved ops; hand-written sequences
// cover start held during EXEC and reset in the middle of a MUL.
// ---------------------------------------------------------------------------
module tb_alu_seq_ctrl;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [1:0] op;
   logic [8:0] a;
   logic [8:0] b;
   logic       busy;
   logic       done;
   logic [8:0] rslt;
   logic       carry;
   logic [2:0] alu_cmd;
   logic [8:0] alu_a;
   logic [8:0] alu_b;
   logic [8:0] alu_rslt;

   int n_vec  = 0;
   int n_miss = 0;

   alu_seq_ctrl dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start_i    (start),
      .op_i       (op),
      .a_i        (a),
      .b_i        (b),
      .busy_o     (busy),
      .done_o     (done),
      .rslt_o     (rslt),
      .carry_o    (carry),
      .alu_cmd_o  (alu_cmd),
      .alu_a_o    (alu_a),
      .alu_b_o    (alu_b),
      .alu_rslt_i (alu_rslt)
   );

   // Combinational ALU model: only ADD is needed by the sequencer.
   assign alu_rslt = (alu_cmd == 3'b000) ? 9'(alu_a + alu_b) : 9'd0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string      name;
      logic [1:0] op;
      logic [8:0] a;
      logic [8:0] b;
      logic [8:0] rslt;
      logic       carry;
      int         lat;      // cycles from start edge to done_o
      int         lat_ee;   // same, with MUL early exit built in
   } vec_t;

   vec_t vecs[11];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Issue one op, wait (bounded) for done_o, compare latency and results.
   task automatic run_op(input string name, input logic [1:0] o, input logic [8:0] va,
                         input logic [8:0] vb, input logic [8:0] er, input logic ec,
                         input int el);
      int lat;
      bit cmd_ok;
      @(negedge clk);
      start = 1'b1; op = o; a = va; b = vb;
      @(posedge clk);
      #1 start = 1'b0;
      lat    = 0;
      cmd_ok = 1'b1;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (alu_cmd !== 3'b000) cmd_ok = 1'b0;
         if (done === 1'b1) begin
            lat = k;
            break;
         end
      end
      check({name, " latency"}, 32'(lat), 32'(el));
      check({name, " rslt"}, 32'(rslt), 32'(er));
      check({name, " carry"}, 32'(carry), 32'(ec));
      check({name, " alu_cmd"}, 32'(cmd_ok), 32'd1);
      @(negedge clk);
      check({name, " done width"}, 32'(done), 32'd0);
      check({name, " idle busy"}, 32'(busy), 32'd0);
   endtask

   initial begin
      int  lat;
      bit  saw_done;

      vecs[0]  = '{"shl c3x3",   2'b00, 9'h0C3, 9'd3,   9'h018, 1'b1, 4,  4};
      vecs[1]  = '{"shl 1ffx0",  2'b00, 9'h1FF, 9'd0,   9'h1FF, 1'b0, 1,  1};
      vecs[2]  = '{"shl 101x12", 2'b00, 9'h101, 9'd12,  9'h000, 1'b1, 10, 10};
      vecs[3]  = '{"mul 20x30",  2'b01, 9'd20,  9'd30,  9'd88,  1'b1, 10, 6};
      vecs[4]  = '{"mul 7x9",    2'b01, 9'd7,   9'd9,   9'd63,  1'b0, 10, 5};
      vecs[5]  = '{"mul 100x3",  2'b01, 9'h100, 9'd3,   9'h100, 1'b1, 10, 3};
      vecs[6]  = '{"rsvd op",    2'b10, 9'd5,   9'd5,   9'd0,   1'b0, 1,  1};
      vecs[7]  = '{"mul 5x0",    2'b01, 9'd5,   9'd0,   9'd0,   1'b0, 10, 1};
      vecs[8]  = '{"shl 001x8",  2'b00, 9'h001, 9'd8,   9'h100, 1'b0, 9,  9};
      vecs[9]  = '{"mul 1ffx1ff",2'b01, 9'h1FF, 9'h1FF, 9'd1,   1'b1, 10, 10};
      vecs[10] = '{"shl 155x1",  2'b00, 9'h155, 9'd1,   9'h0AA, 1'b1, 2,  2};

      rst_n = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
      #3;
      check("rst busy",  32'(busy),    32'd0);
      check("rst done",  32'(done),    32'd0);
      check("rst rslt",  32'(rslt),    32'd0);
      check("rst carry", 32'(carry),   32'd0);
      check("rst cmd",   32'(alu_cmd), 32'd0);
      check("rst alu_a", 32'(alu_a),   32'd0);
      check("rst alu_b", 32'(alu_b),   32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 11; i++) begin
`ifdef MUL_EARLY_EXIT_EN
         lat = vecs[i].lat_ee;
`else
         lat = vecs[i].lat;
`endif
         run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b,
                vecs[i].rslt, vecs[i].carry, lat);
      end

      // start held high through a MUL with a different op presented.
      @(negedge clk);
      start = 1'b1; op = 2'b01; a = 9'd7; b = 9'd9;
      @(posedge clk);
      #1 op = 2'b00; a = 9'h0C3; b = 9'd3;
      @(negedge clk);
      check("held rslt stable", 32'(rslt), 32'h0AA);
      lat = 0;
      for (int k = 2; k <= 40; k++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            lat = k;
            break;
         end
      end
`ifdef MUL_EARLY_EXIT_EN
      check("held latency", 32'(lat), 32'd5);
`else
      check("held latency", 32'(lat), 32'd10);
`endif
      check("held rslt", 32'(rslt), 32'd63);
      check("held carry", 32'(carry), 32'd0);
      @(negedge clk);
      check("held idle busy", 32'(busy), 32'd0);
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      check("held accept busy", 32'(busy), 32'd1);
      lat = 0;
      for (int k = 2; k <= 40; k++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            lat = k;
            break;
         end
      end
      check("held 2nd latency", 32'(lat), 32'd4);
      check("held 2nd rslt", 32'(rslt), 32'h018);
      check("held 2nd carry", 32'(carry), 32'd1);

      // Reset in cycle 4 of a MUL: abort without a done pulse.
      @(negedge clk);
      start = 1'b1; op = 2'b01; a = 9'd20; b = 9'd30;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (3) @(negedge clk);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("abort busy",  32'(busy),  32'd0);
      check("abort done",  32'(done),  32'd0);
      check("abort rslt",  32'(rslt),  32'd0);
      check("abort carry", 32'(carry), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      saw_done = 1'b0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
      end
      check("abort no done", 32'(saw_done), 32'd0);
`ifdef MUL_EARLY_EXIT_EN
      run_op("post-abort mul", 2'b01, 9'd20, 9'd30, 9'd88, 1'b1, 6);
`else
      run_op("post-abort mul", 2'b01, 9'd20, 9'd30, 9'd88, 1'b1, 10);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
